// File: rtl/layer_mac_sequencer.sv
// One 4-input, 4-neuron layer evaluated on a single time-multiplexed MAC.
// Each neuron takes a 6-cycle BIAS/MAC x4/ACT pass; y/fire/done publish together after the last neuron.
module layer_mac_sequencer #(
  parameter int unsigned FRAC_BITS = 4,
  parameter int unsigned ACC_W     = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [7:0] x3,
  input  logic [7:0] w00,
  input  logic [7:0] w01,
  input  logic [7:0] w02,
  input  logic [7:0] w03,
  input  logic [7:0] w10,
  input  logic [7:0] w11,
  input  logic [7:0] w12,
  input  logic [7:0] w13,
  input  logic [7:0] w20,
  input  logic [7:0] w21,
  input  logic [7:0] w22,
  input  logic [7:0] w23,
  input  logic [7:0] w30,
  input  logic [7:0] w31,
  input  logic [7:0] w32,
  input  logic [7:0] w33,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] b3,
  output logic       busy,
  output logic       param_lock,
  output logic       done,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [3:0] fire
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BIAS = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_ACT  = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [1:0]              r_n;
  logic [1:0]              r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic [DW-1:0]           r_x [4];
  logic [DW-1:0]           r_res [4];
  logic [3:0]              r_fire_nxt;
  logic                    r_busy;
  logic                    r_done;
  logic [DW-1:0]           r_y [4];
  logic [3:0]              r_fire;

  logic [DW-1:0]           w_w;
  logic [DW-1:0]           w_x;
  logic [DW-1:0]           w_b;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_bias_acc;
  logic signed [ACC_W-1:0] w_r;
  logic [DW-1:0]           w_relu;
  logic                    w_pos;

  // Weight select: row is the neuron, column is the input index.
  always_comb begin
    w_w = '0;
    case ({r_n, r_k})
      4'd0:  w_w = w00;
      4'd1:  w_w = w01;
      4'd2:  w_w = w02;
      4'd3:  w_w = w03;
      4'd4:  w_w = w10;
      4'd5:  w_w = w11;
      4'd6:  w_w = w12;
      4'd7:  w_w = w13;
      4'd8:  w_w = w20;
      4'd9:  w_w = w21;
      4'd10: w_w = w22;
      4'd11: w_w = w23;
      4'd12: w_w = w30;
      4'd13: w_w = w31;
      4'd14: w_w = w32;
      default: w_w = w33;
    endcase
  end

  always_comb begin
    w_b = '0;
    case (r_n)
      2'd0:    w_b = b0;
      2'd1:    w_b = b1;
      2'd2:    w_b = b2;
      default: w_b = b3;
    endcase
  end

  assign w_x        = r_x[r_k];
  assign w_prod     = $signed({{DW{w_w[DW-1]}}, w_w}) * $signed({{DW{w_x[DW-1]}}, w_x});
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  // Bias moves onto the product scale, which carries 2*FRAC_BITS fraction bits.
  assign w_bias_ext = {{(ACC_W-DW){w_b[DW-1]}}, w_b};
  assign w_bias_acc = w_bias_ext <<< FRAC_BITS;

  assign w_r   = r_acc >>> FRAC_BITS;
  assign w_pos = !r_acc[ACC_W-1] && (r_acc != '0);

  always_comb begin
    w_relu = w_r[DW-1:0];
    if (w_r[ACC_W-1] || (w_r == '0)) begin
      w_relu = '0;
    end else if (|w_r[ACC_W-2:DW-1]) begin
      w_relu = 8'd127;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_BIAS;
      S_BIAS:  w_state_nxt = S_MAC;
      S_MAC:   if (r_k == 2'd3) w_state_nxt = S_ACT;
      default: w_state_nxt = (r_n == 2'd3) ? S_IDLE : S_BIAS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_fire_nxt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fire     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_x[i]   <= '0;
        r_res[i] <= '0;
        r_y[i]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= '{x0, x1, x2, x3};
            r_n    <= '0;
            r_busy <= 1'b1;
          end
        end
        S_BIAS: begin
          r_acc <= w_bias_acc;
          r_k   <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + 2'd1;
        end
        default: begin
          r_res[r_n]      <= w_relu;
          r_fire_nxt[r_n] <= w_pos;
          if (r_n == 2'd3) begin
            // Last neuron: publish all four results at once, the current one straight from ACT.
            r_y    <= '{r_res[0], r_res[1], r_res[2], w_relu};
            r_fire <= {w_pos, r_fire_nxt[2:0]};
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_n <= r_n + 2'd1;
          end
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign param_lock = r_busy;
  assign done       = r_done;
  assign y0         = r_y[0];
  assign y1         = r_y[1];
  assign y2         = r_y[2];
  assign y3         = r_y[3];
  assign fire       = r_fire;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer: latency, ReLU saturation, start/x isolation and mid-run reset.
module tb_layer_mac_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x0, x1, x2, x3;
  logic [7:0] w00, w01, w02, w03, w10, w11, w12, w13;
  logic [7:0] w20, w21, w22, w23, w30, w31, w32, w33;
  logic [7:0] b0, b1, b2, b3;
  logic       busy, param_lock, done;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] fire;

  int checks   = 0;
  int failures = 0;

  layer_mac_sequencer #(.FRAC_BITS(4), .ACC_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w00(w00), .w01(w01), .w02(w02), .w03(w03),
    .w10(w10), .w11(w11), .w12(w12), .w13(w13),
    .w20(w20), .w21(w21), .w22(w22), .w23(w23),
    .w30(w30), .w31(w31), .w32(w32), .w33(w33),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .busy(busy), .param_lock(param_lock), .done(done),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .fire(fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] w, input logic [7:0] b, input logic [7:0] x);
    {w00, w01, w02, w03, w10, w11, w12, w13} = {8{w}};
    {w20, w21, w22, w23, w30, w31, w32, w33} = {8{w}};
    {b0, b1, b2, b3} = {4{b}};
    {x0, x1, x2, x3} = {4{x}};
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] exp_y, input logic [3:0] exp_fire);
    check({tag, "_y"}, {y3, y2, y1, y0}, exp_y);
    check({tag, "_fire"}, 32'(fire), 32'(exp_fire));
  endtask

  // Pulse start, then watch a bounded window; pert adds a mid-run x0 change and a stray start.
  task automatic run_layer(input string tag, input bit pert);
    int done_at   = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int lock_bad  = 0;
    int busy_done = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (param_lock !== busy) lock_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at   = c;
          busy_done = int'(busy);
        end
      end
      if (pert && c == 3)  x0 = 8'h80;
      if (pert && c == 10) start = 1'b1;
      if (pert && c == 11) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'd25);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd24);
    check({tag, "_busy_at_done"}, 32'(busy_done), 32'd0);
    check({tag, "_lock_eq_busy"}, 32'(lock_bad), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0;
    start = 1'b0;
    set_all(8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_lock", 32'(param_lock), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_outputs("reset", 32'd0, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform layer: acc = 4*16*16 = 1024, r = 64 on every neuron.
    set_all(8'd16, 8'd0, 8'd16);
    run_layer("uniform", 1'b0);
    check_outputs("uniform", 32'h40404040, 4'b1111);

    // Neuron 0 goes negative and clamps to zero.
    {w00, w01, w02, w03} = {4{8'hF0}};
    run_layer("neg_n0", 1'b0);
    check_outputs("neg_n0", 32'h40404000, 4'b1110);

    // Positive extreme: acc = 66548, r = 4159, saturates at 127.
    set_all(8'd127, 8'd127, 8'd127);
    run_layer("max_pos", 1'b0);
    check_outputs("max_pos", 32'h7F7F7F7F, 4'b1111);

    // Negative extreme: acc = -67072 must not wrap positive.
    set_all(8'h80, 8'h80, 8'd127);
    run_layer("max_neg", 1'b0);
    check_outputs("max_neg", 32'h00000000, 4'b0000);

    // Bias only on neuron 2: 256 + 1024 = 1280, r = 80.
    set_all(8'd0, 8'd0, 8'd16);
    b2 = 8'd16;
    {w20, w21, w22, w23} = {4{8'd16}};
    run_layer("bias_n2", 1'b0);
    check_outputs("bias_n2", 32'h00500000, 4'b0100);

    // x0 changed mid-run and a stray start: captured x=16 must still give 64 everywhere.
    set_all(8'd16, 8'd0, 8'd16);
    run_layer("isolate", 1'b1);
    check_outputs("isolate", 32'h40404040, 4'b1111);
    check("isolate_idle_after", 32'(busy), 32'd0);

    // Reset at cycle 12 of a run clears everything at once and suppresses done.
    x0 = 8'd16;
    b1 = 8'd32;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_lock", 32'(param_lock), 32'd0);
    check_outputs("midrst", 32'd0, 4'b0000);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (c == 3) rst_n = 1'b1;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // Restart after reset; neuron 1 bias 32 adds 32 -> 96.
    run_layer("restart", 1'b0);
    check_outputs("restart", 32'h40406040, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
- Compute stage directly downstream of the serial parameter register bank.
- Consumes the 20 stored parameters: weights wNk and biases bN for N,k = 0..3.
- Evaluates one 4-input, 4-neuron layer on a snapshot of x0..x3, using a single time-multiplexed multiply-accumulate unit.
- Publishes ReLU-saturated outputs y0..y3 and step flags fire[3:0] together with a one-cycle done pulse.
- Drives param_lock so the upstream loader does not shift parameters while a computation is running.

Parameters:
- FRAC_BITS, 4: fractional bits of the Q-format used by x, w and b (all signed 8-bit, Q(7-FRAC_BITS).FRAC_BITS).
- ACC_W, 18: accumulator width in bits. Must be at least 18 so the worst-case sum of 4 products plus the bias cannot overflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a layer evaluation; sampled only in IDLE.
- x0, x1, x2, x3  in  8 each  signed layer inputs; captured on the start acceptance edge.
- w00..w03, w10..w13, w20..w23, w30..w33  in  8 each  signed weights; wNk multiplies xk for neuron N.
- b0, b1, b2, b3  in  8 each  signed biases.
- busy  out  1  high while a computation is in progress.
- param_lock  out  1  equal to busy; the upstream loader holds its selector at a non-shift value while this is high.
- done  out  1  one-cycle pulse when y/fire are updated.
- y0, y1, y2, y3  out  8 each  unsigned ReLU outputs in the range 0..127.
- fire  out  4  fire[N] = 1 when neuron N's accumulator is > 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, y0..y3, fire, accumulator, neuron index, input index and captured inputs all 0.
- FSM states: IDLE, BIAS, MAC, ACT.
- IDLE:
  - start=1 → capture x0..x3, set neuron n=0, go to BIAS.
  - start=0 → remain in IDLE.
- BIAS (1 cycle): acc = sign_extend(bN) <<< FRAC_BITS, aligning the bias to the Q(2*FRAC_BITS) product scale. Set k=0, go to MAC.
- MAC (4 cycles, k=0..3): acc += signed(wNk) * signed(xk_captured). The full 16-bit product is sign-extended to ACC_W. k increments; after k=3 go to ACT.
- ACT (1 cycle):
  - r = acc >>> FRAC_BITS (arithmetic shift).
  - Result register N = 0 if r <= 0; 127 if r > 127; otherwise r[7:0].
  - fire_next[N] = (acc > 0).
  - If n < 3: n++, go to BIAS.
  - If n = 3: go to IDLE, copy all four result registers to y0..y3 and fire_next to fire, and assert done for exactly that following cycle.
- Latency:
  - 6 cycles per neuron, 24 cycles total.
  - If start is sampled at edge E, done is high and y/fire are valid in the cycle after edge E+24.
- busy / done timing:
  - busy rises after edge E and falls after edge E+24, so busy=0 in the cycle where done=1.
  - A new start may be accepted in that same done cycle; it is sampled in IDLE.
- y/fire hold their values until the next done or reset. Partial results are never visible on y/fire.
- start while busy: ignored; no queueing.
- Inputs:
  - x changes after acceptance have no effect, because x is captured at acceptance.
  - Weights and biases are read live and must be stable while param_lock=1. Changing them mid-run gives undefined results, but the FSM still completes in 24 cycles.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- Arithmetic is signed two's complement throughout; there is no rounding (truncation via arithmetic shift).

Test Plan:
- Reset, then all wNk=16, bN=0, x=16, pulse start → done exactly 24 cycles after start sampled; y0..y3=64; fire=4'b1111; busy high for 24 cycles.
- Neuron 0 weights all -16, others 16, b=0, x=16 → y0=0, fire[0]=0, y1..y3=64, fire=4'b1110.
- w=127, x=127, b=127 everywhere → acc=66548, y all 127 (saturated), fire=4'b1111. Then w=-128, x=127, b=-128 → acc=-67072, no accumulator overflow, y=0, fire=0.
- b2=16, w2k=16, x=16, other neurons zero → y2=80 (64+16), other y=0, fire=4'b0100.
- Pulse start again at cycle 10 of a run, and change x0 at cycle 3 → ignored: single done at cycle 24, results use the x captured at acceptance, param_lock=busy throughout.
- Assert rst_n=0 at cycle 12 of a run → all outputs 0 immediately, no done. Restart after release → correct results after 24 cycles.
